// File: rtl/macci_multi.sv
// macci_multi: Nios multi-cycle custom-instruction MAC, NACC signed accumulators; MACCI_SAT_EN adds saturation + sticky flags.
// Latency: multiply ops raise done MUL_STAGES enabled edges after the start edge; all other ops the cycle after start.
// Backpressure: none; clk_en low freezes everything, and start outside IDLE is dropped.
module macci_multi #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 64,
  parameter int NACC       = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [3:0]  OP_LOAD  = 4'h1;
  localparam logic [3:0]  OP_MAC   = 4'h2;
  localparam logic [3:0]  OP_RDLO  = 4'h3;
  localparam logic [3:0]  OP_RDHI  = 4'h4;
  localparam logic [3:0]  OP_MSU   = 4'h5;
  localparam logic [3:0]  OP_CLR   = 4'h6;
  localparam logic [3:0]  OP_ID    = 4'hF;
  localparam logic [31:0] ID_WORD  = 32'h0ECE4531;
  localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, WB = 2'd2} state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q  [NACC];
  logic signed [ACC_W-1:0]  pipe_q [MUL_STAGES];
  logic [MUL_STAGES-1:0]    vld_q;
  logic [MUL_STAGES-1:0]    vld_d;
  logic [3:0]               op_q;
  logic [3:0]               idx_q;
  logic                     done_q;
  logic [31:0]              result_q;

  logic [3:0]               op_in;
  logic [3:0]               idx_in;
  logic                     idx_ok;
  logic                     is_mul_op;
  logic                     mul_go;
  logic signed [2*DATA_W-1:0] prod_w;
  logic signed [ACC_W-1:0]  prod_last;
  logic signed [ACC_W-1:0]  rd_acc;
  logic signed [ACC_W-1:0]  cur_acc;
  logic signed [ACC_W-1:0]  new_acc;
  logic [31:0]              imm_result;

`ifdef MACCI_SAT_EN
  logic signed [ACC_W:0]    sum_w;
  logic                     sat_evt;
  logic [NACC-1:0]          flag_q;
  localparam logic [3:0]    OP_FLAGS = 4'h7;
`endif

  // Sign-extend an accumulator to 64 bits so lo/hi words are well defined for any ACC_W.
  function automatic logic [63:0] sx64(input logic signed [ACC_W-1:0] v);
    return 64'(v);
  endfunction

  assign op_in     = n[3:0];
  assign idx_in    = n[7:4];
  assign idx_ok    = int'(idx_in) < NACC;
  assign is_mul_op = (op_in == OP_LOAD) || (op_in == OP_MAC) || (op_in == OP_MSU);
  assign mul_go    = (state_q == IDLE) && start && is_mul_op && idx_ok;
  assign vld_d     = (vld_q << 1) | MUL_STAGES'(mul_go);

  assign prod_w    = $signed(dataa[DATA_W-1:0]) * $signed(datab[DATA_W-1:0]);
  assign prod_last = pipe_q[MUL_STAGES-1];

  always_comb begin
    rd_acc  = '0;
    cur_acc = '0;
    for (int k = 0; k < NACC; k++) begin
      if (int'(idx_in) == k) rd_acc = acc_q[k];
      if (int'(idx_q) == k) cur_acc = acc_q[k];
    end
  end

`ifdef MACCI_SAT_EN
  always_comb begin
    case (op_q)
      OP_MAC:  sum_w = {cur_acc[ACC_W-1], cur_acc} + {prod_last[ACC_W-1], prod_last};
      OP_MSU:  sum_w = {cur_acc[ACC_W-1], cur_acc} - {prod_last[ACC_W-1], prod_last};
      default: sum_w = {prod_last[ACC_W-1], prod_last};
    endcase
    sat_evt = sum_w[ACC_W] != sum_w[ACC_W-1];
    new_acc = sum_w[ACC_W-1:0];
    if (sat_evt) new_acc = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  always_comb begin
    case (op_q)
      OP_MAC:  new_acc = cur_acc + prod_last;
      OP_MSU:  new_acc = cur_acc - prod_last;
      default: new_acc = prod_last;
    endcase
  end
`endif

  always_comb begin
    imm_result = BAD_WORD;
    case (op_in)
      OP_ID:   imm_result = ID_WORD;
      OP_RDLO: if (idx_ok) imm_result = 32'(sx64(rd_acc));
      OP_RDHI: if (idx_ok) imm_result = 32'(sx64(rd_acc) >> 32);
      OP_CLR:  if (idx_ok) imm_result = result_q;
`ifdef MACCI_SAT_EN
      OP_FLAGS: imm_result = 32'(flag_q);
`endif
      default: imm_result = BAD_WORD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int k = 0; k < NACC; k++) acc_q[k] <= '0;
      for (int k = 0; k < MUL_STAGES; k++) pipe_q[k] <= '0;
    end else if (clk_en) begin
      vld_q  <= vld_d;
      done_q <= 1'b0;
      if (mul_go) begin
        pipe_q[0] <= ACC_W'(prod_w);
        op_q      <= op_in;
        idx_q     <= idx_in;
      end
      for (int k = 1; k < MUL_STAGES; k++) pipe_q[k] <= pipe_q[k-1];
      case (state_q)
        IDLE: begin
          if (mul_go) begin
            state_q <= vld_d[MUL_STAGES-1] ? WB : MUL;
          end else if (start) begin
            done_q   <= 1'b1;
            result_q <= imm_result;
            if (op_in == OP_CLR && idx_ok) begin
              for (int k = 0; k < NACC; k++)
                if (int'(idx_in) == k) acc_q[k] <= '0;
            end
          end
        end
        MUL: if (vld_d[MUL_STAGES-1]) state_q <= WB;
        WB: begin
          for (int k = 0; k < NACC; k++)
            if (int'(idx_q) == k) acc_q[k] <= new_acc;
          result_q <= 32'(sx64(new_acc));
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MACCI_SAT_EN
  // Flags are sticky: LOAD and CLEAR reset them, MAC/MSU only ever set them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= '0;
    end else if (clk_en) begin
      for (int k = 0; k < NACC; k++) begin
        if (state_q == IDLE && start && op_in == OP_CLR && idx_ok && int'(idx_in) == k)
          flag_q[k] <= 1'b0;
        else if (state_q == WB && int'(idx_q) == k)
          flag_q[k] <= (op_q != OP_LOAD) && (flag_q[k] || sat_evt);
      end
    end
  end
`endif

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_macci_multi.sv
// Randomised and directed bench for macci_multi against a 64-bit arithmetic reference model.
module tb_macci_multi;
  localparam int NACC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [7:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  longint          m_acc [NACC];
  logic [NACC-1:0] m_flag;
  logic [31:0]     m_res;

  macci_multi #(.DATA_W(32), .ACC_W(64), .NACC(NACC), .MUL_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: plain signed 64-bit arithmetic on the architectural accumulators.
  function automatic void model_op(input logic [7:0] nn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] er, output int el);
    logic [3:0]  op;
    int          i;
    longint      p, cur, s;
    logic [63:0] v;
    op = nn[3:0];
    i  = int'(nn[7:4]);
    p  = longint'($signed(a)) * longint'($signed(b));
    er = 32'hDEADBEEF;
    el = 0;
    if (op == 4'hF) er = 32'h0ECE4531;
`ifdef MACCI_SAT_EN
    else if (op == 4'h7) er = 32'(m_flag);
`endif
    else if (op >= 4'h1 && op <= 4'h6 && i < NACC) begin
      cur = m_acc[i];
      case (op)
        4'h1: begin m_acc[i] = p; m_flag[i] = 1'b0; end
        4'h2, 4'h5: begin
          s = (op == 4'h2) ? cur + p : cur - p;
`ifdef MACCI_SAT_EN
          if ((op == 4'h2) ? (cur[63] == p[63] && s[63] != cur[63])
                           : (cur[63] != p[63] && s[63] != cur[63])) begin
            s = cur[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            m_flag[i] = 1'b1;
          end
`endif
          m_acc[i] = s;
        end
        4'h6: begin m_acc[i] = 0; m_flag[i] = 1'b0; end
        default: ;
      endcase
      v = m_acc[i];
      case (op)
        4'h1, 4'h2, 4'h5: begin er = v[31:0]; el = 2; end
        4'h3: er = v[31:0];
        4'h4: er = v[63:32];
        default: er = m_res;
      endcase
    end
    m_res = er;
  endfunction

  // Drive one instruction; lat = enabled edges after the start edge until done, -1 on timeout.
  task automatic issue(input logic [7:0] nn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic d_after);
    int cyc;
    @(negedge clk);
    n = nn; dataa = a; datab = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    lat = (done === 1'b1) ? cyc : -1;
    res = result;
    @(negedge clk);
    d_after = done;
  endtask

  task automatic run(input logic [7:0] nn, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output int lat, output logic [31:0] er, output int el);
    logic d_after;
    model_op(nn, a, b, er, el);
    issue(nn, a, b, res, lat, d_after);
    total++;
    if (d_after !== 1'b0) begin
      bad++;
      $display("FAIL done_width n=%h: done still %b one cycle later, want 0", nn, d_after);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
    for (int k = 0; k < NACC; k++) m_acc[k] = 0;
    m_flag = '0; m_res = '0;
    repeat (3) @(negedge clk);
    total++;
    if (done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: done=%b result=%h, want 0/00000000", done, result);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_release: done=%b result=%h, want 0/00000000", done, result);
    end
  endtask

  task automatic test_id_invalid();
    logic [31:0] res, er;
    int lat, el;
    run(8'h0F, 32'h1234, 32'h5678, res, lat, er, el);
    total++;
    if (res !== 32'h0ECE4531 || lat !== 0) begin
      bad++;
      $display("FAIL id: result=%h lat=%0d, want 0ece4531 lat 0", res, lat);
    end
    run(8'h09, 32'h1, 32'h1, res, lat, er, el);
    total++;
    if (res !== 32'hDEADBEEF || lat !== 0) begin
      bad++;
      $display("FAIL bad_op: result=%h lat=%0d, want deadbeef lat 0", res, lat);
    end
    run(8'h41, 32'h7, 32'h9, res, lat, er, el);
    total++;
    if (res !== 32'hDEADBEEF || lat !== 0) begin
      bad++;
      $display("FAIL bad_idx: result=%h lat=%0d, want deadbeef lat 0", res, lat);
    end
    for (int k = 1; k < NACC; k++) begin
      run({4'(k), 4'h3}, 32'h0, 32'h0, res, lat, er, el);
      total++;
      if (res !== 32'h0) begin
        bad++;
        $display("FAIL bad_idx_untouched acc%0d: result=%h, want 00000000", k, res);
      end
    end
  endtask

  task automatic test_sign_latency();
    logic [31:0] res, er;
    int lat, el;
    run(8'h01, 32'hFFFFFFFF, 32'h00000002, res, lat, er, el);
    total++;
    if (res !== 32'hFFFFFFFE || lat !== 2) begin
      bad++;
      $display("FAIL load_sign: result=%h lat=%0d, want fffffffe lat 2", res, lat);
    end
    run(8'h03, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== 32'hFFFFFFFE) begin
      bad++;
      $display("FAIL read_lo_sign: result=%h, want fffffffe", res);
    end
    run(8'h04, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL read_hi_sign: result=%h, want ffffffff", res);
    end
  endtask

  task automatic test_isolation();
    logic [31:0] res, er;
    int lat, el;
    run(8'h01, 32'd5, 32'd5, res, lat, er, el);
    repeat (3) run(8'h12, 32'd1000, 32'd1000, res, lat, er, el);
    run(8'h13, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== 32'h002DC6C0) begin
      bad++;
      $display("FAIL iso_acc1: result=%h, want 002dc6c0", res);
    end
    run(8'h03, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== 32'h00000019) begin
      bad++;
      $display("FAIL iso_acc0: result=%h, want 00000019", res);
    end
    run(8'h15, 32'd1000, 32'd1000, res, lat, er, el);
    run(8'h13, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== 32'h001E8480) begin
      bad++;
      $display("FAIL iso_msu: result=%h, want 001e8480", res);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res, er, want_lo, want_hi, want_fl;
    int lat, el;
`ifdef MACCI_SAT_EN
    want_lo = 32'hFFFFFFFF; want_hi = 32'h7FFFFFFF; want_fl = 32'h00000004;
`else
    want_lo = 32'h00000003; want_hi = 32'hBFFFFFFD; want_fl = 32'hDEADBEEF;
`endif
    run(8'h21, 32'h7FFFFFFF, 32'h7FFFFFFF, res, lat, er, el);
    repeat (2) run(8'h22, 32'h7FFFFFFF, 32'h7FFFFFFF, res, lat, er, el);
    run(8'h23, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== want_lo) begin
      bad++;
      $display("FAIL ovf_lo: result=%h, want %h", res, want_lo);
    end
    run(8'h24, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== want_hi) begin
      bad++;
      $display("FAIL ovf_hi: result=%h, want %h", res, want_hi);
    end
    run(8'h07, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== want_fl || lat !== 0) begin
      bad++;
      $display("FAIL ovf_flags: result=%h lat=%0d, want %h lat 0", res, lat, want_fl);
    end
    run(8'h26, 32'h0, 32'h0, res, lat, er, el);
    run(8'h07, 32'h0, 32'h0, res, lat, er, el);
    total++;
    if (res !== er) begin
      bad++;
      $display("FAIL ovf_clear_flags: result=%h, want %h", res, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] res, er, a, b;
    logic [3:0]  op, idx;
    int lat, el;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0:       op = 4'h1;
        1, 2:    op = 4'h2;
        3:       op = 4'h5;
        4:       op = 4'h3;
        5:       op = 4'h4;
        6:       op = 4'h6;
        7:       op = 4'hF;
        8:       op = 4'h7;
        default: op = 4'($urandom);
      endcase
      idx = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom; b = $urandom;
      end else begin
        a = 32'($urandom_range(0, 2000)) - 32'd1000;
        b = 32'($urandom_range(0, 2000)) - 32'd1000;
      end
      run({idx, op}, a, b, res, lat, er, el);
      total++;
      if (res !== er || lat !== el) begin
        bad++;
        $display("FAIL random n=%h a=%h b=%h: result=%h lat=%0d, want %h lat %0d",
                 {idx, op}, a, b, res, lat, er, el);
      end
    end
  endtask

  task automatic test_stall_busy();
    logic [31:0] er;
    int el, edges, extra;
    model_op(8'h32, 32'd3, 32'd7, er, el);
    @(negedge clk);
    n = 8'h32; dataa = 32'd3; datab = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 clk_en = 1'b1; start = 1'b1; n = 8'h0F;
    edges = 5;
    while (done !== 1'b1 && edges < 60) begin
      @(posedge clk);
      #1 start = 1'b0;
      edges++;
      @(negedge clk);
    end
    total++;
    if (edges !== 7 || result !== er) begin
      bad++;
      $display("FAIL stall_latency: edges=%0d result=%h, want 7 and %h", edges, result, er);
    end
    clk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL done_hold_stall: done=%b, want 1", done);
    end
    clk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_drop: done=%b, want 0", done);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra !== 0 || result !== er) begin
      bad++;
      $display("FAIL busy_start_ignored: extra dones=%0d result=%h, want 0 and %h", extra, result, er);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res, er;
    int lat, el, extra;
    @(negedge clk);
    n = 8'h02; dataa = 32'd11; datab = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_midop: done=%b result=%h, want 0/00000000", done, result);
    end
    for (int k = 0; k < NACC; k++) m_acc[k] = 0;
    m_flag = '0; m_res = '0;
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL reset_abort_done: dones=%0d after reset, want 0", extra);
    end
    for (int k = 0; k < NACC; k++) begin
      run({4'(k), 4'h3}, 32'h0, 32'h0, res, lat, er, el);
      total++;
      if (res !== 32'h0 || lat !== 0) begin
        bad++;
        $display("FAIL reset_clears acc%0d: result=%h lat=%0d, want 00000000 lat 0", k, res, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_invalid();
    test_sign_latency();
    test_isolation();
    test_overflow();
    test_random();
    test_stall_busy();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/macci_multi.md
Name: macci_multi

Overview:
- Parametrised Nios II multi-cycle custom-instruction MAC engine; next generation of the single-accumulator custom MAC.
- Provides NACC independent signed accumulators, a pipelined multiplier, multiply-subtract and clear operations, and configurable operand/accumulator widths.
- Sits on the Nios custom-instruction port; the CPU drives n/start/dataa/datab, then waits for done and reads result.

Parameters:
- DATA_W, 32, signed operand width taken from dataa[DATA_W-1:0] / datab[DATA_W-1:0]; 8..32.
- ACC_W, 64, accumulator width; 2*DATA_W <= ACC_W <= 64.
- NACC, 4, number of accumulators; 1..16.
- MUL_STAGES, 2, product pipeline registers; >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  Nios clock enable; when low, all state is frozen.
- start  in  1  instruction strobe; sampled when idle and clk_en=1.
- n  in  8  n[3:0] = opcode, n[7:4] = accumulator index.
- dataa  in  32  operand A.
- datab  in  32  operand B.
- done  out  1  one-cycle completion pulse.
- result  out  32  return value; holds until the next result-writing op.

Behaviour:
- Reset (reset_n=0, asynchronous): all accumulators = 0, done = 0, result = 0, FSM = IDLE, pipeline valid bits = 0. Reset mid-operation aborts the op; no done is issued.
- Arithmetic: operands are sign-extended to ACC_W. The signed product is 2*DATA_W bits, sign-extended to ACC_W. Accumulation is modulo 2^ACC_W (wraps).
- Opcodes:
  - 0x1 LOAD: acc[i] = a*b
  - 0x2 MAC: acc[i] += a*b
  - 0x5 MSU: acc[i] -= a*b
  - 0x3 READ_LO: result = acc[i][31:0]
  - 0x4 READ_HI: result = acc[i][ACC_W-1:32], sign-extended to 32 bits
  - 0x6 CLEAR: acc[i] = 0, result unchanged
  - 0xF ID: result = 0x0ECE4531; index ignored
  - Any other opcode: result = 0xDEADBEEF
  - Index i >= NACC on opcodes 1-6: result = 0xDEADBEEF; no accumulator changes.
- FSM states: IDLE, MUL, WB.
  - IDLE + start + multiply op (1/2/5, valid index): capture operands, opcode and index at edge E0 -> MUL.
  - MUL: advance the product pipeline for MUL_STAGES enabled edges -> WB.
  - WB: at the same edge the last product stage completes, update acc[i], set result = new acc[i][31:0], pulse done -> IDLE.
  - Multiply ops therefore pulse done in the cycle after edge E(MUL_STAGES). With the default, done is high in the 3rd cycle counted from the start cycle.
  - Non-multiply ops, invalid opcodes and invalid indices: done and result are registered at E0; done is high in the next cycle; FSM stays in IDLE.
- done: high for exactly one clk_en-qualified cycle. If clk_en is low while done=1, done holds until the next enabled edge.
- Handshake: start while not in IDLE is ignored (no queuing). start with clk_en=0 is ignored.
- clk_en=0: pipeline, FSM, accumulators, done and result all hold; latency stretches by the number of disabled cycles.
- Only the addressed accumulator changes; all others are untouched.

Optional Feature:
- Macro: MACCI_SAT_EN.
- Defined:
  - LOAD/MAC/MSU saturate to the signed ACC_W limits (0x7FFF..F / 0x8000..0).
  - Each accumulator has a sticky overflow flag, set on any saturation event and cleared by CLEAR, LOAD or reset.
  - Opcode 0x7 returns result = {zero-pad, flags[NACC-1:0]} with done after 1 cycle.
- Undefined: accumulation wraps, no flags are implemented, and opcode 0x7 returns 0xDEADBEEF.

Test Plan:
- ID, invalid op, invalid index: after reset, n=0x0F -> result 0x0ECE4531, done 1 cycle later. n=0x09 -> 0xDEADBEEF. n=0x41 (NACC=4) -> 0xDEADBEEF, acc1..acc3 unchanged.
- Sign handling and latency: LOAD n=0x01 with a=0xFFFFFFFF, b=0x00000002 -> done in the 3rd cycle, result 0xFFFFFFFE. READ_LO -> 0xFFFFFFFE; READ_HI -> 0xFFFFFFFF.
- Channel isolation: LOAD acc0 with 5*5, then MAC n=0x12 three times with 1000*1000 -> READ_LO acc1 (n=0x13) = 0x002DC6C0, READ_LO acc0 = 0x00000019. MSU n=0x15 with 1000*1000 -> acc1 lo = 0x001E8480.
- Overflow: LOAD acc2 with 0x7FFFFFFF*0x7FFFFFFF, then MAC twice -> acc2 = 0xBFFFFFFD00000003 without the macro. With MACCI_SAT_EN: acc2 = 0x7FFFFFFFFFFFFFFF and opcode 0x7 returns 0x00000004. CLEAR n=0x26 clears the flag.
- Stall and busy: hold clk_en=0 for 5 cycles mid-MAC -> done delayed by exactly 5 cycles, acc result correct. start pulsed while busy -> ignored, only one done observed.
- Reset mid-op: assert reset_n=0 during MUL of a MAC -> done=0, result=0 immediately. After release, READ_LO of all accumulators returns 0x00000000.
